timing_recovery_ctrl: RTL and testbench
=======================================

TIMING_RECOVERY_CTRL -- requirements
Module: timing_recovery_ctrl

Interface
REQ-001 ACQ_SYMS, 32, update_data pulses spent in ACQ before the gear shift to TRACK (range 2..255).
REQ-002 WDOG_CYCLES, 64, cycles without update_data that trigger a watchdog restart (range 16..255).
REQ-003 clk  input  1  16 MHz sample clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  receiver on; low forces IDLE.
REQ-006 mode  input  2  requested standard (1 = 802.15.4, other = BLE); sampled only on IDLE exit.
REQ-007 update_data  input  1  per-symbol strobe from the timing-recovery datapath.
REQ-008 sync_found  input  1  one-cycle pulse: access address/SFD matched.
REQ-009 pkt_done  input  1  one-cycle pulse: packet end.
REQ-010 tr_rst  output  1  active-low soft reset to the timing-recovery datapath.
REQ-011 select  output  2  standard select to the datapath.
REQ-012 sample_point  output  3  data sample point, constant 2.
REQ-013 e_k_shift  output  4  error gain shift.
REQ-014 tau_shift  output  5  tau gain shift.
REQ-015 locked  output  1  high only in LOCK.
REQ-016 state  output  3  current state encoding.
REQ-017 wdog_evt  output  1  one-cycle pulse on a watchdog restart.

Function
REQ-018 States: IDLE=0, FLUSH=1, ACQ=2, TRACK=3, LOCK=4; encodings 5-7 shall return to IDLE on the next cycle.
REQ-019 enable low shall force IDLE on the next edge from any state, with highest priority.
REQ-020 IDLE: tr_rst=0; enable high -> latch mode into select, go to FLUSH.
REQ-021 FLUSH: tr_rst=0 for exactly 2 cycles, then ACQ; the symbol counter clears on entry.
REQ-022 ACQ/TRACK/LOCK: tr_rst=1.
REQ-023 ACQ: the symbol counter increments on each update_data; the ACQ_SYMS-th pulse moves the FSM to TRACK.
REQ-024 sync_found in ACQ or TRACK -> LOCK; it wins over a same-cycle gear shift; it is ignored in LOCK, IDLE and FLUSH.
REQ-025 LOCK: pkt_done -> FLUSH; pkt_done is ignored in every other state.
REQ-026 Gear table for e_k_shift / tau_shift: IDLE/FLUSH/ACQ 1/9; TRACK 2/10; LOCK 3/11; add 1 to tau_shift when select==1.
REQ-027 Gear outputs and locked shall be decoded from registered state and select only, with no input-to-output combinational path, and shall be valid in the first cycle of each state.
REQ-028 select shall change only on the IDLE->FLUSH transition.
REQ-029 The symbol counter shall saturate and not wrap.

Reset
REQ-030 On rst low, asynchronously: state=IDLE, select=0, tr_rst=0, locked=0, wdog_evt=0, all counters 0.
REQ-031 Release of rst shall take effect on the next clk edge; reset mid-packet shall abandon the packet with no residual state.

Configuration
REQ-032 Macro TR_CTRL_WATCHDOG_EN defined: a cycle counter runs in ACQ/TRACK/LOCK, clears on update_data and on state entry, and on reaching WDOG_CYCLES moves the FSM to FLUSH and pulses wdog_evt for one cycle.
REQ-033 Watchdog restart versus other events in the same cycle: enable low wins; the watchdog beats sync_found and pkt_done.
REQ-034 Macro TR_CTRL_WATCHDOG_EN undefined: no watchdog logic, wdog_evt tied 0, and the port remains present.

Structure
REQ-035 Package tr_ctrl_pkg shall hold the state encodings, the gear-table constants, and the SAMPLE_POINT constant (2).
REQ-036 The watchdog shall live in sub-module tr_watchdog (counter, clear, terminal pulse), instantiated only under TR_CTRL_WATCHDOG_EN.

Verification
REQ-037 Reset, then enable=1 with mode=0: tr_rst is low for 2 cycles after IDLE exit, then ACQ with e_k_shift=1, tau_shift=9, select=0.
REQ-038 ACQ_SYMS=4, four update_data pulses: TRACK on the edge of the 4th pulse, e_k_shift=2, tau_shift=10; with mode=1, tau_shift=11.
REQ-039 sync_found coincident with the 4th ACQ pulse: LOCK, locked=1, e_k_shift=3, tau_shift=11; then pkt_done: FLUSH, 2 cycles tr_rst=0, then ACQ.
REQ-040 With the watchdog enabled: no update_data for 64 cycles in TRACK -> wdog_evt pulses once and the FSM enters FLUSH; with the macro off, the FSM stays in TRACK.
REQ-041 enable dropped in LOCK, and rst asserted mid-TRACK: IDLE next edge / immediately, with locked=0 and tr_rst=0; mode changed mid-packet leaves select unchanged.

Source files
------------

// File: rtl/tr_ctrl_pkg.sv
// Shared definitions for the timing-recovery controller: state encodings,
// gear-table constants, counter widths and the gear decode helpers.
package tr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_ACQ   = 3'd2,
        ST_TRACK = 3'd3,
        ST_LOCK  = 3'd4
    } tr_state_t;

    localparam logic [2:0] SAMPLE_POINT = 3'd2;
    localparam logic [1:0] SEL_154      = 2'd1;

    localparam logic [3:0] EK_ACQ    = 4'd1;
    localparam logic [3:0] EK_TRACK  = 4'd2;
    localparam logic [3:0] EK_LOCK   = 4'd3;
    localparam logic [4:0] TAU_ACQ   = 5'd9;
    localparam logic [4:0] TAU_TRACK = 5'd10;
    localparam logic [4:0] TAU_LOCK  = 5'd11;

    localparam int FLUSH_CYCLES = 2;
    localparam int FLUSH_CNT_W  = 2;
    localparam int SYM_CNT_W    = 8;
    localparam int WDOG_CNT_W   = 8;

    // IDLE and FLUSH share the acquisition gear so the loop restarts wide open.
    function automatic logic [3:0] gear_ek(input tr_state_t s);
        case (s)
            ST_TRACK: return EK_TRACK;
            ST_LOCK:  return EK_LOCK;
            default:  return EK_ACQ;
        endcase
    endfunction

    function automatic logic [4:0] gear_tau(input tr_state_t s, input logic [1:0] sel);
        logic [4:0] base;
        case (s)
            ST_TRACK: base = TAU_TRACK;
            ST_LOCK:  base = TAU_LOCK;
            default:  base = TAU_ACQ;
        endcase
        return base + ((sel == SEL_154) ? 5'd1 : 5'd0);
    endfunction

endpackage

// File: rtl/tr_watchdog.sv
// Symbol-activity watchdog: counts cycles without update_data while the
// receiver is running and flags expiry once WDOG_CYCLES have elapsed.
module tr_watchdog
    import tr_ctrl_pkg::*;
#(
    parameter int WDOG_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_kick,
    input  logic i_restart,
    output logic o_expire
);

    logic [WDOG_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!i_run || i_kick || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + WDOG_CNT_W'(1);
        end
    end

    // Expiry is decoded from the registered count and the kick only, so the
    // FSM can consume it without forming a loop through i_restart.
    assign o_expire = i_run && !i_kick && (r_cnt == WDOG_CNT_W'(WDOG_CYCLES - 1));

endmodule

// File: rtl/timing_recovery_ctrl.sv
// Timing-recovery control FSM: IDLE/FLUSH/ACQ/TRACK/LOCK with gear shifting.
// Optional symbol watchdog enabled by defining TR_CTRL_WATCHDOG_EN.
module timing_recovery_ctrl
    import tr_ctrl_pkg::*;
#(
    parameter int ACQ_SYMS    = 32,
    parameter int WDOG_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       update_data,
    input  logic       sync_found,
    input  logic       pkt_done,
    output logic       tr_rst,
    output logic [1:0] select,
    output logic [2:0] sample_point,
    output logic [3:0] e_k_shift,
    output logic [4:0] tau_shift,
    output logic       locked,
    output logic [2:0] state,
    output logic       wdog_evt
);

    if (ACQ_SYMS < 2 || ACQ_SYMS > 255 || WDOG_CYCLES < 16 || WDOG_CYCLES > 255) begin : g_param_range
        $error("timing_recovery_ctrl: ACQ_SYMS or WDOG_CYCLES out of range");
    end

    tr_state_t              r_state;
    tr_state_t              w_next_state;
    logic [1:0]             r_select;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic [SYM_CNT_W-1:0]   r_sym_cnt;
    logic                   w_active;
    logic                   w_wdog_expire;
    logic                   w_flush_done;
    logic                   w_acq_done;

    assign w_active     = (r_state == ST_ACQ) || (r_state == ST_TRACK) || (r_state == ST_LOCK);
    assign w_flush_done = (r_flush_cnt == FLUSH_CNT_W'(FLUSH_CYCLES - 1));
    assign w_acq_done   = update_data && (r_sym_cnt == SYM_CNT_W'(ACQ_SYMS - 1));

    // Priority: enable low, then watchdog restart, then per-state events.
    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = ST_IDLE;
        end else if (w_wdog_expire) begin
            w_next_state = ST_FLUSH;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_FLUSH;
                ST_FLUSH: if (w_flush_done) w_next_state = ST_ACQ;
                ST_ACQ: begin
                    if (sync_found)      w_next_state = ST_LOCK;
                    else if (w_acq_done) w_next_state = ST_TRACK;
                end
                ST_TRACK: if (sync_found) w_next_state = ST_LOCK;
                ST_LOCK:  if (pkt_done)   w_next_state = ST_FLUSH;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_select    <= '0;
            r_flush_cnt <= '0;
            r_sym_cnt   <= '0;
        end else begin
            r_state <= w_next_state;

            if (r_state == ST_IDLE && w_next_state == ST_FLUSH) begin
                r_select <= mode;
            end

            if (r_state == ST_FLUSH && w_next_state == ST_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + FLUSH_CNT_W'(1);
            end else begin
                r_flush_cnt <= '0;
            end

            // Every path into ACQ passes through FLUSH, which restarts the count.
            if (w_next_state == ST_FLUSH) begin
                r_sym_cnt <= '0;
            end else if (r_state == ST_ACQ && update_data && r_sym_cnt != '1) begin
                r_sym_cnt <= r_sym_cnt + SYM_CNT_W'(1);
            end
        end
    end

    assign tr_rst       = w_active;
    assign select       = r_select;
    assign sample_point = SAMPLE_POINT;
    assign e_k_shift    = gear_ek(r_state);
    assign tau_shift    = gear_tau(r_state, r_select);
    assign locked       = (r_state == ST_LOCK);
    assign state        = r_state;

`ifdef TR_CTRL_WATCHDOG_EN
    logic w_state_change;
    logic r_wdog_evt;

    assign w_state_change = (w_next_state != r_state);

    tr_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_active),
        .i_kick    (update_data),
        .i_restart (w_state_change),
        .o_expire  (w_wdog_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog_evt <= 1'b0;
        end else begin
            r_wdog_evt <= w_wdog_expire && enable;
        end
    end

    assign wdog_evt = r_wdog_evt;
`else
    assign w_wdog_expire = 1'b0;
    assign wdog_evt      = 1'b0;
`endif

endmodule

// File: tb/tb_timing_recovery_ctrl.sv
// Self-checking bench for timing_recovery_ctrl against a behavioural model.
module tb_timing_recovery_ctrl;

    localparam int ACQ  = 4;
    localparam int WDOG = 64;
`ifdef TR_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       update_data = 1'b0;
    logic       sync_found = 1'b0;
    logic       pkt_done = 1'b0;
    logic       tr_rst;
    logic [1:0] select;
    logic [2:0] sample_point;
    logic [3:0] e_k_shift;
    logic [4:0] tau_shift;
    logic       locked;
    logic [2:0] state;
    logic       wdog_evt;

    int errors = 0;
    int checks = 0;

    // Model state: 0 idle, 1 flush, 2 acq, 3 track, 4 lock
    int m_state = 0;
    int m_sel = 0;
    int m_flush_left = 0;
    int m_syms = 0;
    int m_quiet = 0;
    bit m_wdog = 1'b0;

    logic [19:0] obs;
    assign obs = {state, tr_rst, select, sample_point, e_k_shift, tau_shift, locked, wdog_evt};

    timing_recovery_ctrl #(
        .ACQ_SYMS    (ACQ),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mode         (mode),
        .update_data  (update_data),
        .sync_found   (sync_found),
        .pkt_done     (pkt_done),
        .tr_rst       (tr_rst),
        .select       (select),
        .sample_point (sample_point),
        .e_k_shift    (e_k_shift),
        .tau_shift    (tau_shift),
        .locked       (locked),
        .state        (state),
        .wdog_evt     (wdog_evt)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] exp_vec();
        int ek;
        int tau;
        ek  = (m_state == 3) ? 2 : (m_state == 4) ? 3 : 1;
        tau = ek + 8 + ((m_sel == 1) ? 1 : 0);
        return {3'(m_state), (m_state >= 2 && m_state <= 4), 2'(m_sel), 3'd2,
                4'(ek), 5'(tau), (m_state == 4), m_wdog};
    endfunction

    task automatic model_reset();
        m_state = 0; m_sel = 0; m_flush_left = 0; m_syms = 0; m_quiet = 0; m_wdog = 1'b0;
    endtask

    task automatic model_step();
        int nxt;
        bit running;
        bit expire;
        if (!rst) begin
            model_reset();
            return;
        end
        running = (m_state >= 2 && m_state <= 4);
        expire  = WD && running && !update_data && (m_quiet == WDOG - 1);
        nxt = m_state;
        if (!enable) nxt = 0;
        else if (expire) nxt = 1;
        else begin
            case (m_state)
                0: begin nxt = 1; m_sel = int'(mode); end
                1: begin m_flush_left--; if (m_flush_left == 0) nxt = 2; end
                2: begin
                    if (sync_found) nxt = 4;
                    else if (update_data) begin
                        m_syms++;
                        if (m_syms == ACQ) nxt = 3;
                    end
                end
                3: if (sync_found) nxt = 4;
                4: if (pkt_done) nxt = 1;
                default: nxt = 0;
            endcase
        end
        if (nxt == 1 && m_state != 1) begin
            m_flush_left = 2;
            m_syms = 0;
        end
        if (nxt != m_state || update_data || !running) m_quiet = 0;
        else m_quiet++;
        m_wdog  = expire && enable;
        m_state = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic go_acq(input logic [1:0] md, input string tag);
        enable = 1'b0;
        tick();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL %s_idle: got %h expected %h", tag, obs, exp_vec()); end
        enable = 1'b1;
        mode = md;
        repeat (3) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL %s_enter: got %h expected %h", tag, obs, exp_vec()); end
        end
    endtask

    task automatic send_pulses(input int n, input bit sync_last, input string tag);
        int gap;
        for (int p = 0; p < n; p++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                tick();
                checks++;
                if (obs !== exp_vec()) begin errors++; $display("FAIL %s_gap: got %h expected %h", tag, obs, exp_vec()); end
            end
            update_data = 1'b1;
            sync_found  = sync_last && (p == n - 1);
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL %s_pulse: got %h expected %h", tag, obs, exp_vec()); end
            update_data = 1'b0;
            sync_found  = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #2;
        model_reset();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, exp_vec()); end
        checks++;
        if ({state, tr_rst, select, locked, wdog_evt} !== 8'h00) begin
            errors++; $display("FAIL reset_zero: got %h expected 00", {state, tr_rst, select, locked, wdog_evt});
        end
        enable = 1'b1;
        tick();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reset_held: got %h expected %h", obs, exp_vec()); end
        enable = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reset_release: got %h expected %h", obs, exp_vec()); end
    endtask

    task automatic test_acq_entry();
        int low_cnt;
        low_cnt = 0;
        enable = 1'b1;
        mode = 2'd0;
        repeat (3) begin
            tick();
            if (tr_rst === 1'b0 && state !== 3'd0) low_cnt++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL acq_entry_step: got %h expected %h", obs, exp_vec()); end
        end
        checks++;
        if (low_cnt !== 2) begin errors++; $display("FAIL acq_flush_len: got %0d expected 2", low_cnt); end
        checks++;
        if ({state, tr_rst, e_k_shift, tau_shift, select} !== {3'd2, 1'b1, 4'd1, 5'd9, 2'd0}) begin
            errors++; $display("FAIL acq_gear: got %h expected %h", {state, tr_rst, e_k_shift, tau_shift, select},
                               {3'd2, 1'b1, 4'd1, 5'd9, 2'd0});
        end
    endtask

    task automatic test_gear_shift(input logic [1:0] md);
        logic [4:0] tau_req;
        tau_req = (md == 2'd1) ? 5'd11 : 5'd10;
        go_acq(md, "gear");
        send_pulses(ACQ, 1'b0, "gear");
        checks++;
        if ({state, e_k_shift, tau_shift, select} !== {3'd3, 4'd2, tau_req, md}) begin
            errors++; $display("FAIL gear_track_m%0d: got %h expected %h", md, {state, e_k_shift, tau_shift, select},
                               {3'd3, 4'd2, tau_req, md});
        end
    endtask

    task automatic test_sync_lock();
        int low_cnt;
        go_acq(2'd0, "lock");
        send_pulses(ACQ, 1'b1, "lock");
        checks++;
        if ({state, locked, e_k_shift, tau_shift} !== {3'd4, 1'b1, 4'd3, 5'd11}) begin
            errors++; $display("FAIL lock_gear: got %h expected %h", {state, locked, e_k_shift, tau_shift},
                               {3'd4, 1'b1, 4'd3, 5'd11});
        end
        mode = 2'd1;
        update_data = 1'b1;
        sync_found = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL lock_hold: got %h expected %h", obs, exp_vec()); end
        end
        update_data = 1'b0;
        sync_found = 1'b0;
        checks++;
        if (select !== 2'd0) begin errors++; $display("FAIL lock_select_kept: got %0d expected 0", select); end
        pkt_done = 1'b1;
        low_cnt = 0;
        tick();
        pkt_done = 1'b0;
        repeat (2) begin
            if (tr_rst === 1'b0) low_cnt++;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL lock_flush: got %h expected %h", obs, exp_vec()); end
            tick();
        end
        checks++;
        if ({low_cnt[3:0], state, tr_rst} !== {4'd2, 3'd2, 1'b1}) begin
            errors++; $display("FAIL lock_reacq: got %h expected %h", {low_cnt[3:0], state, tr_rst}, {4'd2, 3'd2, 1'b1});
        end
    endtask

    task automatic test_watchdog();
        int pulses;
        int first_flush;
        pulses = 0;
        first_flush = -1;
        go_acq(2'd0, "wdog");
        send_pulses(ACQ, 1'b0, "wdog");
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (wdog_evt === 1'b1) pulses++;
            if (state === 3'd1 && first_flush < 0) first_flush = k;
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL wdog_step%0d: got %h expected %h", k, obs, exp_vec()); end
        end
        checks++;
        if (pulses !== (WD ? 1 : 0)) begin errors++; $display("FAIL wdog_pulses: got %0d expected %0d", pulses, WD ? 1 : 0); end
        checks++;
        if (first_flush !== (WD ? 64 : -1)) begin
            errors++; $display("FAIL wdog_restart_at: got %0d expected %0d", first_flush, WD ? 64 : -1);
        end
    endtask

    task automatic test_enable_drop();
        go_acq(2'd1, "endrop");
        sync_found = 1'b1;
        tick();
        sync_found = 1'b0;
        checks++;
        if ({state, locked, tau_shift} !== {3'd4, 1'b1, 5'd12}) begin
            errors++; $display("FAIL endrop_lock: got %h expected %h", {state, locked, tau_shift}, {3'd4, 1'b1, 5'd12});
        end
        enable = 1'b0;
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        checks++;
        if ({state, locked, tr_rst} !== {3'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL endrop_idle: got %h expected 0", {state, locked, tr_rst});
        end
        sync_found = 1'b1;
        tick();
        sync_found = 1'b0;
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL endrop_sync_ignored: got %h expected %h", obs, exp_vec()); end
    endtask

    task automatic test_rst_mid_track();
        go_acq(2'd1, "rsttrk");
        send_pulses(ACQ, 1'b0, "rsttrk");
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({state, locked, tr_rst, select, wdog_evt} !== 8'h00) begin
            errors++; $display("FAIL rsttrk_async: got %h expected 00", {state, locked, tr_rst, select, wdog_evt});
        end
        #2 rst = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL rsttrk_restart: got %h expected %h", obs, exp_vec()); end
        end
    endtask

    task automatic test_random();
        int upd_div;
        for (int i = 0; i < 800; i++) begin
            upd_div     = (i < 400) ? 4 : 120;
            enable      = ($urandom_range(0, 63) != 0);
            mode        = 2'($urandom_range(0, 3));
            update_data = ($urandom_range(0, upd_div - 1) == 0);
            sync_found  = ($urandom_range(0, 19) == 0);
            pkt_done    = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random_c%0d: got %h expected %h", i, obs, exp_vec()); end
        end
        update_data = 1'b0;
        sync_found  = 1'b0;
        pkt_done    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_acq_entry();
        test_gear_shift(2'd0);
        test_gear_shift(2'd1);
        test_gear_shift(2'd2);
        test_sync_lock();
        test_watchdog();
        test_enable_drop();
        test_rst_mid_track();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
